// File: rtl/as6s_vp_buffer_pkg.sv
// Shared helpers for the vp_buffer FIFO family: width math and bit counting.
package as6s_vp_buffer_pkg;

  localparam int POPCNT_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [POPCNT_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < POPCNT_W; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/as6s_vp_buffer_skid_ring.sv
// SKID_DEPTH-entry register ring with push/pop, occupancy count and clear.
module as6s_vp_buffer_skid_ring
  import as6s_vp_buffer_pkg::*;
#(
  parameter int SKID_DEPTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic [clog2(SKID_DEPTH):0]    cnt
);

  localparam int PTR_W = clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Power-of-2 depth lets the pointers wrap by natural overflow.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

endmodule

// File: rtl/as6s_vp_buffer_fifo_wr_pipe_adapter.sv
// Valid/ready push stream -> skid ring -> WR_PIPE_STAGE register stages -> FIFO write,
// with credit-based issue so pipeline latency can never overflow the FIFO.
module as6s_vp_buffer_fifo_wr_pipe_adapter
  import as6s_vp_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 128,
  parameter int FIFO_DEEP     = 1 << ADDR_WIDTH,
  parameter int SKID_DEPTH    = 4,
  parameter int WR_PIPE_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_trans_clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic [ADDR_WIDTH:0]   fifo_data_count,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  idle,
  output logic                  stall_int
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int XW  = ADDR_WIDTH + 2;
  localparam int SCW = clog2(SKID_DEPTH) + 1;
  localparam logic [XW-1:0]  DEEP_X    = XW'(FIFO_DEEP);
  localparam logic [SCW-1:0] SKID_FULL = SCW'(SKID_DEPTH);

  logic [SCW-1:0]                           skid_cnt;
  logic [DATA_WIDTH-1:0]                    skid_head;
  logic                                     push;
  logic                                     issue;
  logic [WR_PIPE_STAGE-1:0]                 pipe_val_q, pipe_val_d;
  logic [WR_PIPE_STAGE-1:0][DATA_WIDTH-1:0] pipe_dat_q, pipe_dat_d;
  logic                                     land_q, land_d;
  logic                                     stall_q, stall_d;
  logic [POPCNT_W-1:0]                      pipe_val_w;
  logic [3:0]                               pipe_pop;
  logic [XW-1:0]                            inflight;
  logic [XW-1:0]                            credit_sum;

  // Ready depends only on registered occupancy, never on s_valid.
  assign s_ready = (skid_cnt < SKID_FULL);
  assign push    = s_valid & s_ready;

  as6s_vp_buffer_skid_ring #(
    .SKID_DEPTH (SKID_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (data_trans_clr),
    .push      (push),
    .push_data (s_data),
    .pop       (issue),
    .pop_data  (skid_head),
    .cnt       (skid_cnt)
  );

  // land covers the cycle where a write has left the pipe but the FIFO count
  // has not yet caught up, so credit stays conservative.
  always_comb begin
    pipe_val_w                      = '0;
    pipe_val_w[WR_PIPE_STAGE-1:0]   = pipe_val_q;
    pipe_pop                        = popcount(pipe_val_w);
    inflight                        = XW'(pipe_pop) + XW'(land_q);
    credit_sum                      = XW'(fifo_data_count) + inflight;
    issue = ~data_trans_clr & (skid_cnt != '0) & (credit_sum < DEEP_X);
  end

  always_comb begin
    pipe_val_d    = pipe_val_q;
    pipe_dat_d    = pipe_dat_q;
    pipe_val_d[0] = issue;
    if (issue) pipe_dat_d[0] = skid_head;
    // Data only advances with a valid so the output holds its last write.
    for (int i = 1; i < WR_PIPE_STAGE; i++) begin
      pipe_val_d[i] = pipe_val_q[i-1];
      if (pipe_val_q[i-1]) pipe_dat_d[i] = pipe_dat_q[i-1];
    end
    land_d  = pipe_val_q[WR_PIPE_STAGE-1];
    stall_d = s_valid & ~s_ready;
    if (data_trans_clr) begin
      pipe_val_d = '0;
      pipe_dat_d = '0;
      land_d     = 1'b0;
      stall_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_val_q <= '0;
      pipe_dat_q <= '0;
      land_q     <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      pipe_val_q <= pipe_val_d;
      pipe_dat_q <= pipe_dat_d;
      land_q     <= land_d;
      stall_q    <= stall_d;
    end
  end

  assign fifo_wr_en    = pipe_val_q[WR_PIPE_STAGE-1];
  assign fifo_wr_data  = pipe_dat_q[WR_PIPE_STAGE-1];
  assign stall_int     = stall_q;
  assign pending_count = CW'(skid_cnt) + CW'(pipe_pop);
  assign idle          = (pending_count == '0);

endmodule

// File: tb/tb_as6s_vp_buffer_fifo_wr_pipe_adapter.sv
// Directed + random bench with a FIFO occupancy model and in-order write scoreboard.
module tb_as6s_vp_buffer_fifo_wr_pipe_adapter;

  localparam int AW   = 11;
  localparam int DW   = 128;
  localparam int DEEP = 1 << AW;
  localparam int SD   = 4;
  localparam int WPS  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_trans_clr;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [AW:0]   fifo_data_count;
  logic [AW:0]   pending_count;
  logic          idle;
  logic          stall_int;

  int            errors = 0;
  int            checks = 0;
  int            fifo_cnt = 0;
  logic          rd_req = 1'b0;
  logic          load_req = 1'b0;
  int            load_val = 0;
  int            wr_total = 0;
  int            bursts = 0;
  logic          prev_wr = 1'b0;
  int            wr0;
  int            b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  assign fifo_data_count = fifo_cnt[AW:0];

  as6s_vp_buffer_fifo_wr_pipe_adapter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEEP     (DEEP),
    .SKID_DEPTH    (SD),
    .WR_PIPE_STAGE (WPS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_trans_clr  (data_trans_clr),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_data_count (fifo_data_count),
    .pending_count   (pending_count),
    .idle            (idle),
    .stall_int       (stall_int)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // FIFO model: count rises the cycle after a sampled write; clears with the adapter.
  always @(posedge clk) begin
    if (rst || data_trans_clr) begin
      exp_q.delete();
      fifo_cnt <= 0;
    end else begin
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (load_req) fifo_cnt <= load_val;
      else fifo_cnt <= fifo_cnt + (fifo_wr_en ? 1 : 0) - ((rd_req && fifo_cnt > 0) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pending", DW'(pending_count), DW'(exp_q.size()));
      chk("idle", DW'(idle), DW'(exp_q.size() == 0));
      chk("no_overflow", DW'(fifo_cnt <= DEEP), DW'(1));
      if (fifo_wr_en) begin
        wr_total++;
        if (!prev_wr) bursts++;
        chk("sb_nonempty", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          chk("wr_data_order", fifo_wr_data, exp_d);
        end
      end
      prev_wr = fifo_wr_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; data_trans_clr = 1'b0; s_valid = 1'b0; s_data = '0;
    step(2);
    chk("rst_wr_en", DW'(fifo_wr_en), DW'(0));
    chk("rst_wr_data", fifo_wr_data, DW'(0));
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    chk("rst_idle", DW'(idle), DW'(1));
    chk("rst_pending", DW'(pending_count), DW'(0));
    chk("rst_stall", DW'(stall_int), DW'(0));
    rst = 1'b0;
    step(1);

    // 1: single push latency
    s_valid = 1'b1; s_data = DW'(8'hA5);
    step(1);
    s_valid = 1'b0;
    step(1);
    chk("t1_not_early", DW'(fifo_wr_en), DW'(0));
    step(1);
    chk("t1_wr_en", DW'(fifo_wr_en), DW'(1));
    chk("t1_wr_data", fifo_wr_data, DW'(8'hA5));
    step(2);
    chk("t1_pending", DW'(pending_count), DW'(0));
    chk("t1_idle", DW'(idle), DW'(1));
    chk("t1_hold_data", fifo_wr_data, DW'(8'hA5));

    // 2: streaming at full credit
    wr0 = wr_total; b0 = bursts;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = DW'(32'h1000 + i);
      chk("t2_ready", DW'(s_ready), DW'(1));
      step(1);
      chk("t2_stall", DW'(stall_int), DW'(0));
    end
    s_valid = 1'b0;
    step(6);
    chk("t2_writes", DW'(wr_total - wr0), DW'(100));
    chk("t2_bursts", DW'(bursts - b0), DW'(1));

    data_trans_clr = 1'b1; step(1); data_trans_clr = 1'b0;

    // 3: credit boundary at 2046 of 2048
    load_val = DEEP - 2; load_req = 1'b1; step(1); load_req = 1'b0;
    wr0 = wr_total;
    for (int i = 0; i < 6; i++) begin
      chk("t3_ready", DW'(s_ready), DW'(1));
      s_valid = 1'b1; s_data = DW'(16'h300 + i);
      step(1);
    end
    chk("t3_ready_low", DW'(s_ready), DW'(0));
    s_data = DW'(16'h3FF);
    step(1);
    chk("t3_stall_pulse", DW'(stall_int), DW'(1));
    s_valid = 1'b0;
    step(1);
    chk("t3_stall_clear", DW'(stall_int), DW'(0));
    step(4);
    chk("t3_two_writes", DW'(wr_total - wr0), DW'(2));
    chk("t3_fifo_full", DW'(fifo_cnt), DW'(DEEP));
    chk("t3_pending4", DW'(pending_count), DW'(4));
    rd_req = 1'b1; step(3); rd_req = 1'b0;
    step(8);
    chk("t3_five_writes", DW'(wr_total - wr0), DW'(5));
    chk("t3_pending1", DW'(pending_count), DW'(1));
    chk("t3_fifo_refull", DW'(fifo_cnt), DW'(DEEP));

    data_trans_clr = 1'b1; step(1); data_trans_clr = 1'b0;

    // 4: clear with pipe and skid occupied
    load_val = DEEP; load_req = 1'b1; step(1); load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'(16'h400 + i);
      step(1);
    end
    s_valid = 1'b0;
    chk("t4_skid_full", DW'(pending_count), DW'(4));
    wr0 = wr_total;
    load_val = DEEP - 2; load_req = 1'b1; step(1); load_req = 1'b0;
    step(1);
    chk("t4_pre_clr_pending", DW'(pending_count), DW'(4));
    data_trans_clr = 1'b1; step(1); data_trans_clr = 1'b0;
    chk("t4_pending0", DW'(pending_count), DW'(0));
    chk("t4_ready", DW'(s_ready), DW'(1));
    chk("t4_idle", DW'(idle), DW'(1));
    chk("t4_wr_en", DW'(fifo_wr_en), DW'(0));
    step(5);
    chk("t4_squashed", DW'(wr_total - wr0), DW'(0));
    s_valid = 1'b1; s_data = DW'(8'h5A);
    step(1);
    s_valid = 1'b0;
    step(1);
    chk("t4_not_early", DW'(fifo_wr_en), DW'(0));
    step(1);
    chk("t4_wr_en_5a", DW'(fifo_wr_en), DW'(1));
    chk("t4_wr_data_5a", fifo_wr_data, DW'(8'h5A));
    step(2);

    // 5: rst and clear together with a push offered
    wr0 = wr_total;
    rst = 1'b1; data_trans_clr = 1'b1; s_valid = 1'b1; s_data = DW'(8'h77);
    step(1);
    chk("t5_wr_en", DW'(fifo_wr_en), DW'(0));
    chk("t5_wr_data", fifo_wr_data, DW'(0));
    chk("t5_stall", DW'(stall_int), DW'(0));
    chk("t5_ready", DW'(s_ready), DW'(1));
    chk("t5_idle", DW'(idle), DW'(1));
    chk("t5_pending", DW'(pending_count), DW'(0));
    rst = 1'b0; data_trans_clr = 1'b0; s_valid = 1'b0;
    step(5);
    chk("t5_no_write", DW'(wr_total - wr0), DW'(0));

    // 6: random traffic near the full boundary
    load_val = DEEP - 8; load_req = 1'b1; step(1); load_req = 1'b0;
    wr0 = wr_total;
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 99) < 70);
      s_data  = {$urandom, $urandom, $urandom, $urandom};
      rd_req  = ($urandom_range(0, 99) < 45);
      step(1);
    end
    s_valid = 1'b0; rd_req = 1'b1;
    for (int c = 0; c < 200 && !idle; c++) step(1);
    rd_req = 1'b0;
    chk("t6_drained", DW'(idle), DW'(1));
    chk("t6_some_writes", DW'(wr_total - wr0 > 100), DW'(1));
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
